bip_control: RTL and testbench

Fetch/decode sequencer that sits directly downstream of the BIP program memory and upstream of the accumulator/ALU datapath and data RAM. It drives the instruction address into program memory, consumes the 16-bit instruction word the memory returns one clock later, and decodes it into one cycle of datapath control strobes. It also owns the program counter and halt state. Each instruction takes a fixed 2 clocks (FETCH, EXEC).

---
 rtl/bip_pkg.sv | 45 ++++
 rtl/bip_decoder.sv | 47 ++++
 rtl/bip_control.sv | 85 ++++++++
 tb/tb_bip_control.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared constants, state encoding and control-vector type for the BIP
// fetch/decode sequencer.
package bip_pkg;

    localparam int ADDR_W  = 11;
    localparam int OPC_W   = 5;
    localparam int INSTR_W = OPC_W + ADDR_W;

    localparam logic [OPC_W-1:0] OPC_HALT = 5'd0;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'd2;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'd7;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;
    localparam logic       SEL_B_MEM = 1'b0;
    localparam logic       SEL_B_IMM = 1'b1;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic       wr_ram;
        logic       rd_ram;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op_sub;
        logic       wr_acc;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:ADDR_W];
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Purely combinational opcode decode into datapath control strobes.
// Undefined opcodes yield no strobes and raise illegal.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             illegal
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_HALT: ;
            OPC_STO: begin
                ctrl.wr_ram = 1'b1;
            end
            OPC_LD: begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SEL_A_MEM;
                ctrl.wr_acc = 1'b1;
            end
            OPC_LDI: begin
                ctrl.sel_a  = SEL_A_IMM;
                ctrl.wr_acc = 1'b1;
            end
            OPC_ADD, OPC_SUB: begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_MEM;
                ctrl.op_sub = (opcode == OPC_SUB);
                ctrl.wr_acc = 1'b1;
            end
            OPC_ADDI, OPC_SUBI: begin
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_IMM;
                ctrl.op_sub = (opcode == OPC_SUBI);
                ctrl.wr_acc = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP fetch/decode sequencer: owns pc and halt state, runs a 2-clock
// FETCH/EXEC cycle and presents one cycle of decoded strobes in EXEC.
module bip_control
    import bip_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [ADDR_W-1:0]  operand,
    output logic               wr_ram,
    output logic               rd_ram,
    output logic [1:0]         sel_a,
    output logic               sel_b,
    output logic               op_sub,
    output logic               wr_acc,
    output logic               illegal,
    output logic               halted,
    output state_t             state
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    ctrl_t ctrl_g;
    logic  exec_live;

    bip_decoder u_decoder (
        .opcode  (opcode_of(instr)),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Strobes only exist in EXEC, and are killed by reset within the same
    // cycle so an aborted store never reaches the RAM.
    assign exec_live = (state_q == EXEC) && rst;
    assign ctrl_g    = exec_live ? dec_ctrl : CTRL_NONE;

    assign wr_ram  = ctrl_g.wr_ram;
    assign rd_ram  = ctrl_g.rd_ram;
    assign sel_a   = ctrl_g.sel_a;
    assign sel_b   = ctrl_g.sel_b;
    assign op_sub  = ctrl_g.op_sub;
    assign wr_acc  = ctrl_g.wr_acc;
    assign illegal = exec_live && dec_illegal;

    assign operand = instr[ADDR_W-1:0];
    assign pc_addr = pc_q;
    assign halted  = halted_q;
    assign state   = state_q;

    // instr is only looked at in EXEC, so garbage during FETCH cannot reach state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (opcode_of(instr) == OPC_HALT) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= FETCH;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: expected EXEC-cycle outputs are queued by
// the stimulus and consumed by a negedge monitor.
module tb_bip_control;
    import bip_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [INSTR_W-1:0] instr = 16'hFFFF;
    logic [ADDR_W-1:0]  pc_addr;
    logic [ADDR_W-1:0]  operand;
    logic               wr_ram;
    logic               rd_ram;
    logic [1:0]         sel_a;
    logic               sel_b;
    logic               op_sub;
    logic               wr_acc;
    logic               illegal;
    logic               halted;
    state_t             state;

    int checks = 0;
    int errors = 0;

    logic [29:0]        exp_q[$];
    logic [29:0]        exp_e;
    logic [INSTR_W-1:0] mem [0:2047];
    bit                 mem_en = 1'b0;

    bip_control dut (
        .clk     (clk),
        .rst     (rst),
        .instr   (instr),
        .pc_addr (pc_addr),
        .operand (operand),
        .wr_ram  (wr_ram),
        .rd_ram  (rd_ram),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .op_sub  (op_sub),
        .wr_acc  (wr_acc),
        .illegal (illegal),
        .halted  (halted),
        .state   (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    wire [29:0] act     = {pc_addr, operand, wr_ram, rd_ram, sel_a, sel_b, op_sub, wr_acc, illegal};
    wire [7:0]  strobes = {wr_ram, rd_ram, sel_a, sel_b, op_sub, wr_acc, illegal};

    function automatic logic [29:0] pack(input logic [10:0] p, input logic [10:0] o,
                                         input logic wr, input logic rd, input logic [1:0] sa,
                                         input logic sb, input logic sub, input logic wa,
                                         input logic ill);
        return {p, o, wr, rd, sa, sb, sub, wa, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        cycles(2);
    endtask

    // Registered program memory: address seen before an edge, word after it.
    initial begin
        logic [10:0] a;
        forever begin
            @(negedge clk);
            a = pc_addr;
            @(posedge clk);
            #1;
            if (mem_en) instr = mem[a];
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && state == EXEC) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL exec_unexpected: pc_addr=%0d with no expected entry", pc_addr);
            end else begin
                exp_e = exp_q.pop_front();
                if (act !== exp_e) begin
                    errors++;
                    $display("FAIL exec_decode: got pc=%0d op=%0h str=%b expected pc=%0d op=%0h str=%b",
                             act[29:19], act[18:8], act[7:0], exp_e[29:19], exp_e[18:8], exp_e[7:0]);
                end
            end
        end else begin
            checks++;
            if (strobes !== 8'h0) begin
                errors++;
                $display("FAIL idle_strobes: got %b expected 00000000 (state=%0d rst=%b)",
                         strobes, state, rst);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'hFFFF;

        // Reset hold with the memory's reset word on instr
        rst = 1'b0;
        instr = 16'hFFFF;
        cycles(3);
        @(negedge clk);
        check("rst_pc", 32'(pc_addr), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_state", 32'(state), 32'(FETCH));
        @(posedge clk);
        #1;
        exp_q.push_back(pack(11'd0, 11'h7FF, 0, 0, 2'd0, 0, 0, 0, 1));
        rst = 1'b1;
        @(negedge clk);
        check("c1_state", 32'(state), 32'(FETCH));
        cycles(1);
        @(negedge clk);
        check("c2_state", 32'(state), 32'(EXEC));
        cycles(1);
        check("drain_t1", 32'(exp_q.size()), 0);

        // Short program from memory ending in HALT
        reset_dut();
        mem[0] = 16'h1804; mem[1] = 16'h0801; mem[2] = 16'h1802;
        mem[3] = 16'h1001; mem[4] = 16'h2001; mem[5] = 16'h0000;
        mem_en = 1'b1;
        exp_q.push_back(pack(11'd0, 11'd4, 0, 0, 2'd1, 0, 0, 1, 0));
        exp_q.push_back(pack(11'd1, 11'd1, 1, 0, 2'd0, 0, 0, 0, 0));
        exp_q.push_back(pack(11'd2, 11'd2, 0, 0, 2'd1, 0, 0, 1, 0));
        exp_q.push_back(pack(11'd3, 11'd1, 0, 1, 2'd0, 0, 0, 1, 0));
        exp_q.push_back(pack(11'd4, 11'd1, 0, 1, 2'd2, 0, 0, 1, 0));
        exp_q.push_back(pack(11'd5, 11'd0, 0, 0, 2'd0, 0, 0, 0, 0));
        rst = 1'b1;
        cycles(11);
        @(negedge clk);
        check("halt_exec_halted", 32'(halted), 0);
        cycles(1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halted_flag", 32'(halted), 1);
            check("halted_pc", 32'(pc_addr), 5);
            check("halted_state", 32'(state), 32'(HALTED));
            cycles(1);
        end
        check("drain_t2", 32'(exp_q.size()), 0);
        mem_en = 1'b0;

        // SUBI 5
        reset_dut();
        instr = 16'h3805;
        exp_q.push_back(pack(11'd0, 11'd5, 0, 0, 2'd2, 1, 1, 1, 0));
        exp_q.push_back(pack(11'd1, 11'd5, 0, 0, 2'd2, 1, 1, 1, 0));
        rst = 1'b1;
        cycles(4);
        check("drain_t3", 32'(exp_q.size()), 0);

        // Undefined opcode behaves as NOP with a one-cycle illegal pulse
        reset_dut();
        instr = 16'hF800;
        exp_q.push_back(pack(11'd0, 11'd0, 0, 0, 2'd0, 0, 0, 0, 1));
        exp_q.push_back(pack(11'd1, 11'd0, 0, 0, 2'd0, 0, 0, 0, 1));
        rst = 1'b1;
        cycles(4);
        check("illegal_pc", 32'(pc_addr), 2);
        check("drain_t4", 32'(exp_q.size()), 0);

        // Full pc sweep and wrap
        reset_dut();
        instr = 16'hFFFF;
        for (int i = 0; i < 2048; i++)
            exp_q.push_back(pack(11'(i), 11'h7FF, 0, 0, 2'd0, 0, 0, 0, 1));
        rst = 1'b1;
        cycles(4096);
        check("wrap_pc", 32'(pc_addr), 0);
        check("wrap_halted", 32'(halted), 0);
        check("wrap_state", 32'(state), 32'(FETCH));
        check("drain_t5", 32'(exp_q.size()), 0);

        // Reset dropped during EXEC of a store
        reset_dut();
        instr = 16'h0801;
        exp_q.push_back(pack(11'd0, 11'd1, 1, 0, 2'd0, 0, 0, 0, 0));
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("abort_wr_ram", 32'(wr_ram), 0);
        check("abort_state", 32'(state), 32'(EXEC));
        check("abort_pc_before", 32'(pc_addr), 1);
        cycles(1);
        check("abort_pc_after", 32'(pc_addr), 0);
        check("abort_state_after", 32'(state), 32'(FETCH));
        check("drain_t6a", 32'(exp_q.size()), 0);

        // Reset out of HALTED restarts at address 0
        cycles(1);
        instr = 16'h0000;
        exp_q.push_back(pack(11'd0, 11'd0, 0, 0, 2'd0, 0, 0, 0, 0));
        rst = 1'b1;
        cycles(3);
        check("t6_halted", 32'(halted), 1);
        check("t6_state", 32'(state), 32'(HALTED));
        rst = 1'b0;
        cycles(1);
        check("t6_halted_clr", 32'(halted), 0);
        check("t6_pc_clr", 32'(pc_addr), 0);
        instr = 16'h1803;
        exp_q.push_back(pack(11'd0, 11'd3, 0, 0, 2'd1, 0, 0, 1, 0));
        rst = 1'b1;
        cycles(2);
        check("t6_restart_pc", 32'(pc_addr), 1);
        check("drain_t6b", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
